alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised successor to the core's single-cycle combinational ALU.
- Adds XOR, set-less-than (signed and unsigned), shifts, and status flags.
- Adds iterative unsigned multiply, divide and remainder, driven by a start/ready/done handshake.
- Sits in the execute stage; the core stalls on ready=0 and captures Result on done.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted only when ready=1.
- ALUControl  input  4  operation code, sampled at accept.
- A  input  WIDTH  operand A, sampled at accept.
- B  input  WIDTH  operand B, sampled at accept.
- ready  output  1  block idle, can accept start.
- done  output  1  one-cycle pulse: Result and flags updated.
- Result  output  WIDTH  registered result, held until next done.
- Zero  output  1  Result == 0.
- Negative  output  1  Result[WIDTH-1].
- Carry  output  1  carry out (ADD) or no-borrow (SUB); otherwise 0.
- Overflow  output  1  signed overflow (ADD/SUB only); otherwise 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - Result=0, Zero=1, Negative=0, Carry=0, Overflow=0, done=0, ready=1.
  - FSM returns to IDLE; iteration counter cleared.
  - An in-flight operation is discarded; no done is issued for it.
- Opcodes:
  - 0000 ADD; 0001 SUB (A + ~B + 1); 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLT (signed, result 1 or 0); 0110 SLTU (unsigned).
  - 0111 SLL, 1000 SRL, 1001 SRA; shift by B[SHW-1:0]; upper bits of B ignored.
  - 1010 MUL: low WIDTH bits of A*B, unsigned shift-add.
  - 1011 DIVU: unsigned quotient, restoring division.
  - 1100 REMU: unsigned remainder.
  - 1101-1111: reserved; Result=0, flags computed from the zero result, single-cycle.
- FSM states: IDLE, ITER.
- IDLE:
  - ready=1.
  - Single-cycle op accepted at edge t: Result and flags registered at t+1 and done=1 during cycle t+1; FSM stays IDLE.
  - Back-to-back single-cycle starts give one result per cycle.
  - Iterative op accepted at edge t: operands latched, counter=WIDTH, FSM goes to ITER, ready=0 from cycle t+1.
- ITER:
  - One multiply or divide step per cycle; counter decrements each step.
  - On the step where counter reaches 0: Result and flags written, done=1, FSM returns to IDLE, ready=1.
  - done is asserted exactly WIDTH cycles after the accept edge (cycle t+WIDTH).
  - start while ready=0 is ignored; operands are not resampled.
- Simultaneous events:
  - done and a new accept in the same cycle are legal.
  - The new op overwrites Result at its own completion, not before.
- Divide by zero:
  - No iteration skipped; latency is still WIDTH cycles.
  - DIVU Result = all ones; REMU Result = A.
- Flags:
  - Registered together with Result; unchanged between done pulses.
  - Carry and Overflow are 0 for every op other than ADD/SUB.
- Arithmetic:
  - All operations are modulo 2^WIDTH.
  - MUL discards the upper WIDTH product bits.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF, B=0x00000001 -> done at next cycle; Result=0x80000000, Overflow=1, Negative=1, Carry=0.
- SUB A=B=0x12345678 -> Result=0, Zero=1, Carry=1. SLT A=0xFFFFFFFF, B=1 -> 1. SLTU same operands -> 0.
- SRA A=0x80000000, B=0x00000024 (shift 4) -> Result=0xF8000000. Back-to-back AND then OR -> done on two consecutive cycles with the correct results.
- MUL A=0xFFFFFFFF, B=3 -> ready=0 for 32 cycles; done exactly 32 cycles after accept; Result=0xFFFFFFFD. A start pulsed mid-operation is ignored.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU and REMU 55/0 -> 0xFFFFFFFF and 55, each after 32 cycles.
- rst=0 at cycle 10 of a DIVU -> outputs at reset values immediately (asynchronously); no done pulse; the next ADD completes normally.

Source files
------------

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops through a one-stage pipe,
// plus iterative unsigned MUL/DIVU/REMU under a start/ready/done handshake.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             iter_op;

    logic             vld_p0;
    logic [3:0]       op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH+1:0] ev_p0;

    logic [3:0]       op_it;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] aux;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] aux_nxt;
    logic [WIDTH-1:0] it_res;

    // Returns {carry, overflow, result} for every single-cycle opcode.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]          sum;
        logic [WIDTH-1:0]        res;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          sh;
        logic                    c;
        logic                    v;
        sum = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        sa  = a;
        sb  = b;
        sh  = b[SHW-1:0];
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  res = a << sh;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = sa >>> sh;
            default: res = '0;
        endcase
        return {c, v, res};
    endfunction

    assign accept  = start && ready;
    assign iter_op = (ALUControl == OP_MUL) || (ALUControl == OP_DIVU) ||
                     (ALUControl == OP_REMU);
    assign ev_p0   = alu_eval(op_p0, a_p0, b_p0);

    // Iteration step: shift-add multiply (acc=product, aux=multiplier, opnd=multiplicand)
    // or restoring divide (acc=remainder, aux=dividend shifting into quotient, opnd=divisor).
    assign rem_sh = {acc, aux[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, opnd};

    always_comb begin
        acc_nxt = acc;
        aux_nxt = aux;
        if (op_it == OP_MUL) begin
            acc_nxt = aux[0] ? (acc + opnd) : acc;
            aux_nxt = aux >> 1;
        end else if (!diff[WIDTH]) begin
            acc_nxt = diff[WIDTH-1:0];
            aux_nxt = {aux[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = rem_sh[WIDTH-1:0];
            aux_nxt = {aux[WIDTH-2:0], 1'b0};
        end
    end

    assign it_res = (op_it == OP_DIVU) ? aux_nxt : acc_nxt;

    // Stage p0: operands of an accepted single-cycle op; iterative operand registers.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= ALUControl;
            a_p0  <= A;
            b_p0  <= B;
        end
        if (state == ITER) begin
            acc <= acc_nxt;
            aux <= aux_nxt;
            if (op_it == OP_MUL) begin
                opnd <= opnd << 1;
            end
        end else if (accept && iter_op) begin
            op_it <= ALUControl;
            acc   <= '0;
            aux   <= (ALUControl == OP_MUL) ? B : A;
            opnd  <= (ALUControl == OP_MUL) ? A : B;
        end
    end

    // Output stage: Result/flags written from p0 or from the final iteration step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            vld_p0   <= 1'b0;
            Result   <= '0;
            Zero     <= 1'b1;
            Negative <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_p0 <= accept && !iter_op;
            if (vld_p0) begin
                Result   <= ev_p0[WIDTH-1:0];
                Zero     <= (ev_p0[WIDTH-1:0] == '0);
                Negative <= ev_p0[WIDTH-1];
                Carry    <= ev_p0[WIDTH+1];
                Overflow <= ev_p0[WIDTH];
                done     <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept && iter_op) begin
                        state <= ITER;
                        cnt   <= CW'(WIDTH);
                        ready <= 1'b0;
                    end
                end
                ITER: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state    <= IDLE;
                        ready    <= 1'b1;
                        done     <= 1'b1;
                        Result   <= it_res;
                        Zero     <= (it_res == '0);
                        Negative <= it_res[WIDTH-1];
                        Carry    <= 1'b0;
                        Overflow <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed plan steps plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_multicycle;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    ALUControl = 4'd0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          ready;
    logic          done;
    logic [W-1:0]  Result;
    logic          Zero;
    logic          Negative;
    logic          Carry;
    logic          Overflow;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUControl(ALUControl),
        .A(A), .B(B), .ready(ready), .done(done), .Result(Result),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the opcode's meaning.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic v);
        longint          sa;
        longint          sb;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ur;
        int              s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        s  = int'(b % 32);
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'd0: begin
                ur = ua + ub; r = ur[31:0]; c = (ur > 64'hFFFF_FFFF);
                sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                r = a - b; c = (a >= b);
                sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  r = (ua < ub) ? 32'd1 : 32'd0;
            4'd7:  r = a << s;
            4'd8:  r = a >> s;
            4'd9:  r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'd10: begin ur = ua * ub; r = ur[31:0]; end
            4'd11: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit pulse_mid);
        logic [31:0] r;
        logic        c;
        logic        v;
        int          lat;
        int          exp_lat;
        bit          ready_low;
        model(op, a, b, r, c, v);
        exp_lat = (op == 4'd10 || op == 4'd11 || op == 4'd12) ? W : 1;
        @(negedge clk);
        check({tag, "_ready_in"}, ready, 1);
        ALUControl = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'($urandom);
        check({tag, "_ready_after_accept"}, ready, exp_lat == 1);
        ready_low = 1'b1;
        lat = 0;
        while (lat < W + 8) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (ready) ready_low = 1'b0;
            if (pulse_mid && lat == 10) start = 1'b1;
            if (pulse_mid && lat == 11) start = 1'b0;
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (exp_lat > 1) check({tag, "_ready_low"}, ready_low, 1);
        check({tag, "_result"}, Result, r);
        check({tag, "_zero"}, Zero, r == 0);
        check({tag, "_neg"}, Negative, r[31]);
        check({tag, "_carry"}, Carry, c);
        check({tag, "_ovf"}, Overflow, v);
        check({tag, "_ready_end"}, ready, 1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        logic [31:0] r_and, r_or;
        logic        c_d, v_d;
        int          ndone;

        repeat (3) @(posedge clk);
        #1;
        check("rst_result", Result, 0);
        check("rst_zero", Zero, 1);
        check("rst_neg", Negative, 0);
        check("rst_carry", Carry, 0);
        check("rst_ovf", Overflow, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b1;

        run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("add_ovf_const", Result, 32'h8000_0000);
        check("add_ovf_flag", Overflow, 1);
        run_op("sub_eq", 4'd1, 32'h1234_5678, 32'h1234_5678, 1'b0);
        check("sub_eq_carry", Carry, 1);
        run_op("slt", 4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("slt_const", Result, 1);
        run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("sltu_const", Result, 0);
        run_op("sra", 4'd9, 32'h8000_0000, 32'h0000_0024, 1'b0);
        check("sra_const", Result, 32'hF800_0000);

        // Back-to-back AND then OR.
        model(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, r_and, c_d, v_d);
        model(4'd3, 32'h1200_0001, 32'h0034_0100, r_or, c_d, v_d);
        @(negedge clk);
        ALUControl = 4'd2; A = 32'hF0F0_1234; B = 32'h0FF0_FF00; start = 1'b1;
        @(posedge clk); #1;
        ALUControl = 4'd3; A = 32'h1200_0001; B = 32'h0034_0100;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_and_done", done, 1);
        check("b2b_and_res", Result, r_and);
        @(posedge clk); #1;
        check("b2b_or_done", done, 1);
        check("b2b_or_res", Result, r_or);
        @(posedge clk); #1;
        check("b2b_idle", done, 0);

        run_op("mul", 4'd10, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1);
        check("mul_const", Result, 32'hFFFF_FFFD);
        run_op("divu", 4'd11, 32'd100, 32'd7, 1'b0);
        check("divu_const", Result, 14);
        run_op("remu", 4'd12, 32'd100, 32'd7, 1'b1);
        check("remu_const", Result, 2);
        run_op("divu0", 4'd11, 32'd55, 32'd0, 1'b0);
        check("divu0_const", Result, 32'hFFFF_FFFF);
        run_op("remu0", 4'd12, 32'd55, 32'd0, 1'b0);
        check("remu0_const", Result, 55);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
            if ((op == 4'd11 || op == 4'd12) && $urandom_range(0, 3) == 0) b = 32'd0;
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, i[0]);
        end

        // Asynchronous reset in the middle of a divide.
        run_op("pre_rst", 4'd0, 32'd5, 32'd6, 1'b0);
        @(negedge clk);
        ALUControl = 4'd11; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_result", Result, 0);
        check("arst_zero", Zero, 1);
        check("arst_neg", Negative, 0);
        check("arst_carry", Carry, 0);
        check("arst_ovf", Overflow, 0);
        check("arst_done", done, 0);
        check("arst_ready", ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("arst_no_done", ndone, 0);
        check("arst_result_held", Result, 0);
        run_op("post_rst_add", 4'd0, 32'd3, 32'd4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
